// File: rtl/fabric_reset_ctrl_if.sv
// Signal bundle between the fabric reset controller and its environment.
// The slave side is the controller; the master side drives lock and requests.
interface fabric_reset_ctrl_if;
   logic       LOCK;
   logic       SW_RESET_REQ;
   logic       LOCK_LOST_CLR;
   logic       FAB_RESET_N;
   logic       READY;
   logic       LOCK_LOST;
   logic [1:0] STATE;

   modport slave (
      input  LOCK,
      input  SW_RESET_REQ,
      input  LOCK_LOST_CLR,
      output FAB_RESET_N,
      output READY,
      output LOCK_LOST,
      output STATE
   );

   modport master (
      output LOCK,
      output SW_RESET_REQ,
      output LOCK_LOST_CLR,
      input  FAB_RESET_N,
      input  READY,
      input  LOCK_LOST,
      input  STATE
   );
endinterface

// File: rtl/fabric_reset_ctrl.sv
// Fabric reset generator: qualifies CCC lock, stretches reset, re-asserts on
// lock loss or software request, and keeps a sticky lock-loss flag.
//
//  state     | meaning
//  ----------+----------------------------------------------------------
//  RESET     | waiting for synchronised RESET_N release
//  WAIT_LOCK | counting consecutive cycles of lock_s=1
//  HOLD      | lock qualified, stretching fabric reset
//  RUN       | fabric reset released, READY=1
module fabric_reset_ctrl #(
   parameter int SYNC_STAGES        = 2,
   parameter int LOCK_STABLE_CYCLES = 1024,
   parameter int RESET_HOLD_CYCLES  = 16,
   parameter int CNT_W              = 16
) (
   input logic                 CLK,
   input logic                 RESET_N,
   fabric_reset_ctrl_if.slave  bus
);

   typedef enum logic [1:0] {
      S_RESET     = 2'b00,
      S_WAIT_LOCK = 2'b01,
      S_HOLD      = 2'b10,
      S_RUN       = 2'b11
   } state_t;

   localparam logic [CNT_W-1:0] LOCK_TC = CNT_W'(LOCK_STABLE_CYCLES - 1);
   localparam logic [CNT_W-1:0] HOLD_TC = CNT_W'(RESET_HOLD_CYCLES - 1);

   logic [SYNC_STAGES-1:0] r_rst_sync;
   logic [SYNC_STAGES-1:0] r_lock_sync;
   state_t                 r_state;
   logic [CNT_W-1:0]       r_cnt;
   logic                   r_fab_reset_n;
   logic                   r_ready;
   logic                   r_lock_lost;

   state_t                 w_state_nxt;
   logic [CNT_W-1:0]       w_cnt_nxt;
   logic                   w_lost_set;
   logic                   w_rst_s;
   logic                   w_lock_s;

   assign w_rst_s  = r_rst_sync[SYNC_STAGES-1];
   assign w_lock_s = r_lock_sync[SYNC_STAGES-1];

   // Assertion is async through the flop clears; only release is synchronised.
   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         r_rst_sync  <= '0;
         r_lock_sync <= '0;
      end else begin
         r_rst_sync  <= {r_rst_sync[SYNC_STAGES-2:0], 1'b1};
         r_lock_sync <= {r_lock_sync[SYNC_STAGES-2:0], bus.LOCK};
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_lost_set  = 1'b0;
      case (r_state)
         S_RESET: begin
            w_cnt_nxt = '0;
            if (w_rst_s) w_state_nxt = S_WAIT_LOCK;
         end
         S_WAIT_LOCK: begin
            if (!w_lock_s) begin
               w_cnt_nxt = '0;
            end else if (r_cnt == LOCK_TC) begin
               w_state_nxt = S_HOLD;
               w_cnt_nxt   = '0;
            end else begin
               w_cnt_nxt = r_cnt + 1'b1;
            end
         end
         S_HOLD: begin
            if (!w_lock_s) begin
               w_state_nxt = S_WAIT_LOCK;
               w_cnt_nxt   = '0;
            end else if (r_cnt == HOLD_TC) begin
               w_state_nxt = S_RUN;
               w_cnt_nxt   = '0;
            end else begin
               w_cnt_nxt = r_cnt + 1'b1;
            end
         end
         S_RUN: begin
            // Lock loss takes priority over a simultaneous software request.
            if (!w_lock_s) begin
               w_state_nxt = S_WAIT_LOCK;
               w_cnt_nxt   = '0;
               w_lost_set  = 1'b1;
            end else if (bus.SW_RESET_REQ) begin
               w_state_nxt = S_HOLD;
               w_cnt_nxt   = '0;
            end
         end
         default: begin
            w_state_nxt = S_RESET;
            w_cnt_nxt   = '0;
         end
      endcase
   end

   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         r_state       <= S_RESET;
         r_cnt         <= '0;
         r_fab_reset_n <= 1'b0;
         r_ready       <= 1'b0;
         r_lock_lost   <= 1'b0;
      end else begin
         r_state       <= w_state_nxt;
         r_cnt         <= w_cnt_nxt;
         r_fab_reset_n <= (w_state_nxt == S_RUN);
         r_ready       <= (w_state_nxt == S_RUN);
         if (w_lost_set)             r_lock_lost <= 1'b1;
         else if (bus.LOCK_LOST_CLR) r_lock_lost <= 1'b0;
      end
   end

   assign bus.FAB_RESET_N = r_fab_reset_n;
   assign bus.READY       = r_ready;
   assign bus.LOCK_LOST   = r_lock_lost;
   assign bus.STATE       = r_state;

endmodule

// File: tb/tb_fabric_reset_ctrl.sv
// Directed bench for fabric_reset_ctrl with short qualification/hold windows.
module tb_fabric_reset_ctrl;

   logic CLK;
   logic RESET_N;
   logic clk_en;
   int   n_checks;
   int   n_errors;

   fabric_reset_ctrl_if u_if ();

   fabric_reset_ctrl #(
      .SYNC_STAGES       (2),
      .LOCK_STABLE_CYCLES(8),
      .RESET_HOLD_CYCLES (4),
      .CNT_W             (16)
   ) u_dut (
      .CLK    (CLK),
      .RESET_N(RESET_N),
      .bus    (u_if)
   );

   always #5 CLK = clk_en ? ~CLK : CLK;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   // Advance n rising edges, leaving time 1 unit past the last edge.
   task automatic tick(input int n);
      repeat (n) @(posedge CLK);
      #1;
   endtask

   task automatic check_outs(input string tag, input logic fab, input logic rdy,
                             input logic lost, input logic [1:0] st);
      check_eq({tag, ".fab"},   u_if.FAB_RESET_N, fab);
      check_eq({tag, ".ready"}, u_if.READY,       rdy);
      check_eq({tag, ".lost"},  u_if.LOCK_LOST,   lost);
      check_eq({tag, ".state"}, u_if.STATE,       st);
   endtask

   initial begin
      n_checks          = 0;
      n_errors          = 0;
      CLK               = 1'b0;
      clk_en            = 1'b0;
      RESET_N           = 1'b0;
      u_if.LOCK          = 1'b0;
      u_if.SW_RESET_REQ  = 1'b0;
      u_if.LOCK_LOST_CLR = 1'b0;

      #20;
      check_outs("por_noclk", 1'b0, 1'b0, 1'b0, 2'b00);

      clk_en = 1'b1;
      tick(2);
      RESET_N = 1'b1;
      tick(2);
      check_eq("rst_sync_2", u_if.STATE, 2'b00);
      tick(1);
      check_eq("rst_sync_3", u_if.STATE, 2'b01);

      // Clean lock acquisition: 2 sync + 8 stable + 4 hold = 14 edges.
      u_if.LOCK = 1'b1;
      tick(9);
      check_eq("acq_wait9", u_if.STATE, 2'b01);
      tick(1);
      check_outs("acq_hold10", 1'b0, 1'b0, 1'b0, 2'b10);
      tick(3);
      check_outs("acq_13", 1'b0, 1'b0, 1'b0, 2'b10);
      tick(1);
      check_outs("acq_14", 1'b1, 1'b1, 1'b0, 2'b11);

      // Lock loss in RUN.
      u_if.LOCK = 1'b0;
      tick(2);
      check_outs("loss_2", 1'b1, 1'b1, 1'b0, 2'b11);
      tick(1);
      check_outs("loss_3", 1'b0, 1'b0, 1'b1, 2'b01);
      tick(2);
      check_eq("lost_sticky", u_if.LOCK_LOST, 1'b1);
      u_if.LOCK_LOST_CLR = 1'b1;
      tick(1);
      u_if.LOCK_LOST_CLR = 1'b0;
      check_eq("lost_clr", u_if.LOCK_LOST, 1'b0);

      // Glitch during qualification: no partial credit.
      u_if.LOCK = 1'b1;
      tick(5);
      u_if.LOCK = 1'b0;
      tick(1);
      u_if.LOCK = 1'b1;
      tick(9);
      check_eq("glitch_wait9", u_if.STATE, 2'b01);
      tick(4);
      check_outs("glitch_13", 1'b0, 1'b0, 1'b0, 2'b10);
      tick(1);
      check_outs("glitch_14", 1'b1, 1'b1, 1'b0, 2'b11);

      // Software reset in RUN: exactly 4 low cycles.
      u_if.SW_RESET_REQ = 1'b1;
      tick(1);
      u_if.SW_RESET_REQ = 1'b0;
      check_outs("sw_1", 1'b0, 1'b0, 1'b0, 2'b10);
      tick(3);
      check_outs("sw_4", 1'b0, 1'b0, 1'b0, 2'b10);
      tick(1);
      check_outs("sw_5", 1'b1, 1'b1, 1'b0, 2'b11);

      // Lock loss and SW request together; also set beats a same-cycle clear.
      u_if.LOCK = 1'b0;
      tick(2);
      u_if.SW_RESET_REQ  = 1'b1;
      u_if.LOCK_LOST_CLR = 1'b1;
      tick(1);
      u_if.SW_RESET_REQ  = 1'b0;
      u_if.LOCK_LOST_CLR = 1'b0;
      check_outs("loss_sw", 1'b0, 1'b0, 1'b1, 2'b01);

      // Reach HOLD, then assert RESET_N asynchronously mid-cycle.
      u_if.LOCK = 1'b1;
      tick(10);
      check_eq("pre_rst_hold", u_if.STATE, 2'b10);
      #2;
      RESET_N = 1'b0;
      #1;
      check_outs("async_rst", 1'b0, 1'b0, 1'b0, 2'b00);
      u_if.LOCK = 1'b0;
      tick(2);
      check_eq("rst_held", u_if.STATE, 2'b00);
      RESET_N = 1'b1;
      tick(3);
      check_eq("rerst_wait", u_if.STATE, 2'b01);
      u_if.LOCK = 1'b1;
      tick(13);
      check_outs("requal_13", 1'b0, 1'b0, 1'b0, 2'b10);
      tick(1);
      check_outs("requal_14", 1'b1, 1'b1, 1'b0, 2'b11);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
